// File: rtl/im2col_pkg.sv
// Shared types and constants for the im2col patch extractor.
package im2col_pkg;

    // Default pixel width and kernel size.
    localparam int DATA_W_DFLT = 8;
    localparam int K           = 3;

    // Input pixel beat, MSB first: valid, sof, data.
    typedef struct packed {
        logic                          valid;
        logic                          sof;
        logic signed [DATA_W_DFLT-1:0] data;
    } tIm2ColIn;

    // Output column beat, MSB first: valid, last, 3x3 patch.
    // Element w[i][j] sits at col[DATA_W*(K*i+j) +: DATA_W].
    typedef struct packed {
        logic                           valid;
        logic                           last;
        logic [K*K*DATA_W_DFLT-1:0]     col;
    } tIm2ColOut;

endpackage

// File: rtl/im2col_line_buf.sv
// Fixed-depth delay line: returns the sample written DEPTH enables ago.
module im2col_line_buf #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iEn,
    input  logic signed [DATA_W-1:0] iData,
    output logic signed [DATA_W-1:0] oData
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]            ptr_q;
    logic [PW-1:0]            ptr_d;

    // Read-before-write: the slot about to be overwritten holds the oldest sample.
    assign oData = mem[ptr_q];

    // Circular pointer advance, wrapping at DEPTH-1.
    always_comb begin
        ptr_d = ptr_q;
        if (iEn) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer is the only control state; it alone takes reset.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is data-only and never cleared.
    always_ff @(posedge iClk) begin
        if (iEn) begin
            mem[ptr_q] <= iData;
        end
    end

endmodule

// File: rtl/im2_col.sv
// Raster stream to 3x3 stride-1 unpadded patch columns.
module im2_col
    import im2col_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic      iClk,
    input  logic      iRst,
    input  tIm2ColIn  iData,
    output tIm2ColOut oData
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] c_q, c_d, c_cur;
    logic [RW-1:0] r_q, r_d, r_cur;

    logic                     accept;
    logic                     emit;
    logic                     is_last;
    logic signed [DATA_W-1:0] pix;
    logic signed [DATA_W-1:0] row1_pix;   // same column, one row up
    logic signed [DATA_W-1:0] row2_pix;   // same column, two rows up

    logic signed [DATA_W-1:0] win_q [K][K];
    logic signed [DATA_W-1:0] win_d [K][K];
    logic [K*K*DATA_W-1:0]    col_d;

    tIm2ColOut out_q;

    assign accept = iData.valid;
    assign pix    = iData.data;
    assign oData  = out_q;

    im2col_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
        .iClk  (iClk),
        .iRst  (iRst),
        .iEn   (accept),
        .iData (pix),
        .oData (row1_pix)
    );

    im2col_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
        .iClk  (iClk),
        .iRst  (iRst),
        .iEn   (accept),
        .iData (row1_pix),
        .oData (row2_pix)
    );

    // Position of the current pixel (sof restarts at origin) and next position.
    always_comb begin
        c_cur = iData.sof ? '0 : c_q;
        r_cur = iData.sof ? '0 : r_q;
        c_d   = c_q;
        r_d   = r_q;
        if (accept) begin
            if (c_cur == CW'(IMG_W - 1)) begin
                c_d = '0;
                r_d = (r_cur == RW'(IMG_H - 1)) ? '0 : r_cur + 1'b1;
            end else begin
                c_d = c_cur + 1'b1;
                r_d = r_cur;
            end
        end
    end

    // Window emission only once two full rows and two columns precede the pixel;
    // this also hides any stale line-buffer data after a restart.
    assign emit    = accept && (r_cur >= RW'(2)) && (c_cur >= CW'(2));
    assign is_last = (r_cur == RW'(IMG_H - 1)) && (c_cur == CW'(IMG_W - 1));

    // Shift window left and load the new right-hand column (oldest row on top).
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_d[i][j] = win_q[i][j];
            end
        end
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = row2_pix;
            win_d[1][2] = row1_pix;
            win_d[2][2] = pix;
        end
    end

    // Flatten the post-shift window into the output column layout.
    always_comb begin
        col_d = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                col_d[DATA_W*(K*i+j) +: DATA_W] = win_d[i][j];
            end
        end
    end

    // Counters, window and registered output; col holds when nothing is emitted.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            c_q   <= '0;
            r_q   <= '0;
            out_q <= '0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            c_q         <= c_d;
            r_q         <= r_d;
            win_q       <= win_d;
            out_q.valid <= emit;
            out_q.last  <= emit && is_last;
            if (emit) begin
                out_q.col <= col_d;
            end
        end
    end

endmodule

// File: tb/tb_im2_col.sv
// Randomized and directed bench for im2_col with an image-array reference model.
module tb_im2_col;
    import im2col_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic      clk;
    logic      rst_n;
    tIm2ColIn  din;
    tIm2ColOut dout;

    int total = 0;
    int bad   = 0;

    // Reference model state: frame position and stored image pixels.
    int                  pix_idx = 0;
    logic signed [DW-1:0] img [H][W];
    logic [9*DW-1:0]     held_col = '0;
    logic [9*DW-1:0]     got_q [$];
    logic                got_last [$];

    im2_col #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .iClk  (clk),
        .iRst  (rst_n),
        .iData (din),
        .oData (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pack9(input int p [9]);
        logic [9*DW-1:0] f;
        for (int k = 0; k < 9; k++) f[DW*k +: DW] = DW'(p[k]);
        return f;
    endfunction

    // One clock with the given input; model predicts the output of this edge.
    task automatic step(input logic v, input logic s, input logic signed [DW-1:0] d);
        logic            exp_v;
        logic            exp_l;
        logic [9*DW-1:0] exp_c;
        int              idx, r, c;
        din.valid = v;
        din.sof   = s;
        din.data  = d;
        @(posedge clk);
        exp_v = 1'b0;
        exp_l = 1'b0;
        exp_c = held_col;
        if (v) begin
            idx = s ? 0 : pix_idx;
            r = idx / W;
            c = idx % W;
            img[r][c] = d;
            if (r >= 2 && c >= 2) begin
                exp_v = 1'b1;
                exp_l = (idx == W*H - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_c[DW*(3*i+j) +: DW] = img[r-2+i][c-2+j];
                held_col = exp_c;
            end
            pix_idx = (idx + 1) % (W*H);
        end
        #1;
        check_eq("valid", 128'(dout.valid), 128'(exp_v));
        check_eq("last", 128'(dout.last), 128'(exp_l));
        check_eq("col", 128'(dout.col), 128'(exp_c));
        if (dout.valid) begin
            got_q.push_back(dout.col);
            got_last.push_back(dout.last);
        end
    endtask

    task automatic clear_got();
        got_q.delete();
        got_last.delete();
    endtask

    initial begin
        int p [9];
        din   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_out", 128'(dout), 128'(0));
        rst_n = 1'b1;

        // Plain 4x4 frame, pixels 0..15.
        clear_got();
        for (int k = 0; k < 16; k++) step(1'b1, k == 0, DW'(k));
        step(1'b0, 1'b0, '0);
        check_eq("f1_count", 128'(got_q.size()), 128'(4));
        p = '{0,1,2,4,5,6,8,9,10};
        if (got_q.size() == 4) begin
            check_eq("f1_first", 128'(got_q[0]), 128'(pack9(p)));
            p = '{5,6,7,9,10,11,13,14,15};
            check_eq("f1_last_col", 128'(got_q[3]), 128'(pack9(p)));
            check_eq("f1_last_flag", 128'(got_last[3]), 128'(1));
        end

        // Same frame with idle cycles interleaved.
        clear_got();
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, DW'($urandom));
            step(1'b1, k == 0, DW'(k));
        end
        check_eq("gap_count", 128'(got_q.size()), 128'(4));

        // Two back-to-back frames.
        clear_got();
        for (int k = 0; k < 32; k++) step(1'b1, (k % 16) == 0, DW'(k));
        check_eq("b2b_count", 128'(got_q.size()), 128'(8));
        p = '{16,17,18,20,21,22,24,25,26};
        if (got_q.size() == 8) check_eq("b2b_second_first", 128'(got_q[4]), 128'(pack9(p)));

        // Asynchronous reset mid-frame, then a frame with no sof.
        for (int k = 0; k < 10; k++) step(1'b1, k == 0, DW'(k));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_clear", 128'(dout), 128'(0));
        pix_idx  = 0;
        held_col = '0;
        din = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        clear_got();
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, DW'(k + 40));
        check_eq("post_rst_count", 128'(got_q.size()), 128'(4));

        // sof reasserted at pixel 6 restarts the frame.
        clear_got();
        for (int k = 0; k < 6; k++) step(1'b1, k == 0, DW'(k));
        for (int k = 0; k < 10; k++) step(1'b1, k == 0, DW'(k + 100));
        check_eq("restart_first_only", 128'(got_q.size()), 128'(0));
        step(1'b1, 1'b0, DW'(110));
        check_eq("restart_emit", 128'(got_q.size()), 128'(1));
        for (int k = 11; k < 16; k++) step(1'b1, 1'b0, DW'(k + 100));
        check_eq("restart_count", 128'(got_q.size()), 128'(4));

        // Signed extremes in the first window.
        clear_got();
        for (int k = 0; k < 16; k++)
            step(1'b1, k == 0, (k == 0) ? -8'sd128 : (k == 10) ? 8'sd127 : DW'(k));
        if (got_q.size() > 0) begin
            check_eq("neg_slot", 128'(got_q[0][7:0]), 128'(8'h80));
            check_eq("pos_slot", 128'(got_q[0][71:64]), 128'(8'h7F));
        end else begin
            check_eq("signed_count", 128'(got_q.size()), 128'(4));
        end

        // Random traffic: gaps, random data, occasional sof at or off frame start.
        for (int n = 0; n < 600; n++) begin
            logic v, s;
            v = ($urandom % 10) < 7;
            s = v && ((pix_idx == 0 && ($urandom % 2) == 1) || ($urandom % 40) == 0);
            step(v, s, DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/im2_col.md
IM2_COL -- requirements
Module: im2_col

Interface
REQ-001 SHALL have parameter IMG_W, default 8, image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 8, image height in pixels (>=3).
REQ-003 SHALL have parameter DATA_W, default 8, signed pixel width.
REQ-004 SHALL have port iClk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port iRst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port iData  input  DATA_W+2  packed struct tIm2ColIn, MSB first: valid, sof (first pixel of frame), data (signed pixel).
REQ-007 SHALL have port oData  output  9*DATA_W+2  packed struct tIm2ColOut, MSB first: valid, last (final window of frame), col (9 pixels).

Function
REQ-008 SHALL convert a raster-order pixel stream (row 0 first, left to right) into 3x3, stride-1, unpadded patches, one output column per complete window.
REQ-009 SHALL accept a pixel only when iData.valid=1; cycles with valid=0 change no state and produce oData.valid=0 on the next cycle.
REQ-010 SHALL track column counter c (0..IMG_W-1) and row counter r (0..IMG_H-1) for the accepted pixel; sof=1 forces that pixel to c=0, r=0.
REQ-011 SHALL advance c after each accepted pixel, wrapping to 0 and incrementing r at IMG_W-1; after r=IMG_H-1, c=IMG_W-1 both wrap to 0 for the next frame.
REQ-012 SHALL hold the previous two image rows in two line buffers of IMG_W entries each, plus a 3x3 window register shifted left on each accepted pixel.
REQ-013 SHALL emit a window when the accepted pixel has r>=2 and c>=2; windows with c<2 (wrapping across row boundaries) SHALL be suppressed.
REQ-014 SHALL place window element w[i][j] (i=0 top/oldest row, j=0 leftmost column) at col bits [DATA_W*(3*i+j)+DATA_W-1 : DATA_W*(3*i+j)].
REQ-015 SHALL register oData with latency exactly 1 cycle from the accepting edge of the window's bottom-right pixel.
REQ-016 SHALL assert oData.last together with the window whose bottom-right pixel is r=IMG_H-1, c=IMG_W-1.
REQ-017 SHALL produce exactly (IMG_W-2)*(IMG_H-2) valid outputs per complete frame, with back-to-back frames needing no idle cycles.
REQ-018 SHALL pass pixel values bit-exact (no arithmetic, sign preserved).
REQ-019 SHALL treat sof mid-frame as a restart: counters reset; stale line-buffer data is never emitted because of the r>=2 rule.
REQ-020 SHALL drive oData.valid=0 and oData.last=0 whenever no window is emitted; col content is then don't-care but SHALL hold its last value.

Reset
REQ-021 SHALL, while iRst=0, asynchronously clear c, r, window registers and all oData fields to 0.
REQ-022 SHALL NOT require reset of line-buffer storage (data-only memory).
REQ-023 SHALL after reset release treat the first accepted pixel as c=0, r=0 regardless of sof.

Structure
REQ-024 SHALL take tIm2ColIn, tIm2ColOut, DATA_W default and kernel size K=3 from shared package im2col_pkg.
REQ-025 SHALL implement each line buffer as one instance of sub-module im2col_line_buf (IMG_W-deep delay line, enable = accepted pixel).

Verification
REQ-026 SHALL verify: IMG_W=IMG_H=4, pixels 0..15 continuous, sof on 0 -> 4 outputs; first, one cycle after pixel 10 accepted, col={0,1,2,4,5,6,8,9,10}; last-flagged col={5,6,7,9,10,11,13,14,15}.
REQ-027 SHALL verify: same frame with valid=0 gaps inserted every other cycle -> identical 4 columns, each 1 cycle after its completing pixel.
REQ-028 SHALL verify: two back-to-back 4x4 frames (second pixels 16..31, sof on 16) -> 8 outputs, second frame first col={16,17,18,20,21,22,24,25,26}, no column mixes frames.
REQ-029 SHALL verify: iRst=0 asserted after pixel 9 of a frame -> oData cleared immediately; fresh frame after release gives correct 4 columns.
REQ-030 SHALL verify: sof reasserted at pixel 6 of a frame -> counters restart, first output only after new row 2, col 2.
REQ-031 SHALL verify: pixels -128 and 127 in a window -> appear as 8'h80 and 8'h7F in the correct slots.
